// File: rtl/z_core_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional operand/result cache for back-to-back DIV/REM on the same operands: Z_CORE_DIV_CACHE_EN.
module z_core_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start,
    input  logic [1:0]            div_op,
    input  logic [DATA_WIDTH-1:0] div_in1,
    input  logic [DATA_WIDTH-1:0] div_in2,
    input  logic                  div_flush,
    output logic                  div_busy,
    output logic                  div_done,
    output logic [DATA_WIDTH-1:0] div_out
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_quoNeg;
    logic                  r_remNeg;
    logic                  r_isRem;

    logic                  w_accept;
    logic                  w_isSigned;
    logic                  w_isRem;
    logic                  w_divZero;
    logic                  w_overflow;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_specialOut;
    logic [DATA_WIDTH-1:0] w_mag1;
    logic [DATA_WIDTH-1:0] w_mag2;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_nextRem;
    logic [DATA_WIDTH-1:0] w_nextQuo;
    logic [DATA_WIDTH-1:0] w_quoFix;
    logic [DATA_WIDTH-1:0] w_remFix;
    logic                  w_lastIter;
    logic                  w_cacheHit;
    logic [DATA_WIDTH-1:0] w_cacheOut;

    assign w_accept   = (r_state == IDLE) && div_start && !div_flush;
    assign w_isSigned = ~div_op[0];
    assign w_isRem    = div_op[1];
    assign w_divZero  = (div_in2 == '0);
    assign w_overflow = w_isSigned && (div_in1 == MIN_NEG) && (div_in2 == ALL_ONES);
    assign w_special  = w_divZero | w_overflow;
    assign w_specialOut = w_isRem ? (w_divZero ? div_in1 : '0)
                                  : (w_divZero ? ALL_ONES : MIN_NEG);
    assign w_mag1 = (w_isSigned && div_in1[DATA_WIDTH-1]) ? -div_in1 : div_in1;
    assign w_mag2 = (w_isSigned && div_in2[DATA_WIDTH-1]) ? -div_in2 : div_in2;

    // A set top remainder bit means the shifted value exceeds any 32-bit divisor.
    assign w_shifted  = {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]};
    assign w_ge       = r_rem[DATA_WIDTH-1] | (w_shifted >= r_divisor);
    assign w_nextRem  = w_ge ? (w_shifted - r_divisor) : w_shifted;
    assign w_nextQuo  = {r_quo[DATA_WIDTH-2:0], w_ge};
    assign w_quoFix   = r_quoNeg ? -w_nextQuo : w_nextQuo;
    assign w_remFix   = r_remNeg ? -w_nextRem : w_nextRem;
    assign w_lastIter = (r_state == CALC) && !div_flush && (r_cnt == LAST_ITER);

`ifdef Z_CORE_DIV_CACHE_EN
    logic [DATA_WIDTH-1:0] r_in1;
    logic [DATA_WIDTH-1:0] r_in2;
    logic                  r_signed;
    logic [DATA_WIDTH-1:0] r_cIn1;
    logic [DATA_WIDTH-1:0] r_cIn2;
    logic [DATA_WIDTH-1:0] r_cQuo;
    logic [DATA_WIDTH-1:0] r_cRem;
    logic                  r_cSigned;
    logic                  r_cValid;

    assign w_cacheHit = r_cValid && (r_cIn1 == div_in1) && (r_cIn2 == div_in2)
                        && (r_cSigned == w_isSigned);
    assign w_cacheOut = w_isRem ? r_cRem : r_cQuo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in1     <= '0;
            r_in2     <= '0;
            r_signed  <= 1'b0;
            r_cIn1    <= '0;
            r_cIn2    <= '0;
            r_cQuo    <= '0;
            r_cRem    <= '0;
            r_cSigned <= 1'b0;
            r_cValid  <= 1'b0;
        end else if (div_flush) begin
            r_cValid <= 1'b0;
        end else if (w_accept && !w_special && !w_cacheHit) begin
            r_in1    <= div_in1;
            r_in2    <= div_in2;
            r_signed <= w_isSigned;
            r_cValid <= 1'b0;
        end else if (w_lastIter) begin
            r_cIn1    <= r_in1;
            r_cIn2    <= r_in2;
            r_cSigned <= r_signed;
            r_cQuo    <= w_quoFix;
            r_cRem    <= w_remFix;
            r_cValid  <= 1'b1;
        end
    end
`else
    assign w_cacheHit = 1'b0;
    assign w_cacheOut = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_nextState = (w_special || w_cacheHit) ? FIX : CALC;
            CALC: begin
                if (div_flush)                 w_nextState = IDLE;
                else if (r_cnt == LAST_ITER)   w_nextState = FIX;
            end
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        div_busy = (r_state != IDLE);
        div_done = (r_state == FIX);
    end

    assign div_out = r_out;

    // Shortcut completions load the result at accept; the iterative path loads it on its final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_quoNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_isRem   <= 1'b0;
            r_out     <= '0;
        end else if (w_accept) begin
            if (w_special) begin
                r_out <= w_specialOut;
            end else if (w_cacheHit) begin
                r_out <= w_cacheOut;
            end else begin
                r_cnt     <= '0;
                r_rem     <= '0;
                r_quo     <= w_mag1;
                r_divisor <= w_mag2;
                r_quoNeg  <= w_isSigned & (div_in1[DATA_WIDTH-1] ^ div_in2[DATA_WIDTH-1]);
                r_remNeg  <= w_isSigned & div_in1[DATA_WIDTH-1];
                r_isRem   <= w_isRem;
            end
        end else if (r_state == CALC && !div_flush) begin
            r_rem <= w_nextRem;
            r_quo <= w_nextQuo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_ITER) r_out <= r_isRem ? w_remFix : w_quoFix;
        end
    end
endmodule

// File: tb/tb_z_core_div_unit.sv
// Self-checking bench for z_core_div_unit: vector table plus flush/reset/busy corner sequences.
// Expected latencies follow the Z_CORE_DIV_CACHE_EN build setting.
module tb_z_core_div_unit;
    localparam int W = 32;
`ifdef Z_CORE_DIV_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         div_start;
    logic [1:0]   div_op;
    logic [W-1:0] div_in1;
    logic [W-1:0] div_in2;
    logic         div_flush;
    logic         div_busy;
    logic         div_done;
    logic [W-1:0] div_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[18];
    bit          cValid;
    logic [31:0] cA;
    logic [31:0] cB;
    bit          cSgn;
    logic [31:0] modelOut;

    always #5 clk = ~clk;

    z_core_div_unit #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_start (div_start),
        .div_op    (div_op),
        .div_in1   (div_in1),
        .div_in2   (div_in2),
        .div_flush (div_flush),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_out   (div_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Predict latency, push the expectation, and present the request (caller drops div_start).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] out);
        exp_t e;
        bit   sp;
        sp    = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        e.out = out;
        e.a   = a;
        e.b   = b;
        e.sgn = !op[0];
        if (sp) e.lat = 1;
        else if (CACHE_EN && cValid && cA == a && cB == b && cSgn == !op[0]) e.lat = 1;
        else begin
            e.lat  = 33;
            cValid = 1'b0;
        end
        sb.push_back(e);
        div_op    = op;
        div_in1   = a;
        div_in2   = b;
        div_start = 1'b1;
    endtask

    // Called at the negedge of T+1; follows the operation until done, flush or reset.
    task automatic waitDone(input string name, input int pulseAt, input int flushAt, input int rstAt);
        exp_t e;
        int   cyc;
        bit   busyOk;
        e      = sb.pop_front();
        cyc    = 1;
        busyOk = 1'b1;
        while (!div_done && cyc <= 40) begin
            if (div_busy !== 1'b1) busyOk = 1'b0;
            if (cyc == pulseAt) begin
                div_start = 1'b1;
                div_op    = 2'd1;
                div_in1   = 32'd50;
                div_in2   = 32'd5;
            end
            if (pulseAt != 0 && cyc == pulseAt + 1) div_start = 1'b0;
            if (cyc == flushAt) begin
                div_flush = 1'b1;
                @(negedge clk);
                div_flush = 1'b0;
                cValid    = 1'b0;
                checkOutput({name, "/busyBefore"}, 32'(busyOk), 32'd1);
                checkOutput({name, "/busyAfterFlush"}, 32'(div_busy), 32'd0);
                checkOutput({name, "/doneAfterFlush"}, 32'(div_done), 32'd0);
                checkOutput({name, "/outHeld"}, div_out, modelOut);
                return;
            end
            if (cyc == rstAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst      = 1'b0;
                cValid   = 1'b0;
                modelOut = 32'h0;
                checkOutput({name, "/busyAfterRst"}, 32'(div_busy), 32'd0);
                checkOutput({name, "/doneAfterRst"}, 32'(div_done), 32'd0);
                checkOutput({name, "/outAfterRst"}, div_out, 32'h0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        if (!div_done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s/timeout: got no done expected done within 40 cycles", name);
            return;
        end
        checkOutput({name, "/latency"}, 32'(cyc), 32'(e.lat));
        checkOutput({name, "/busyWhileRunning"}, 32'(busyOk & div_busy), 32'd1);
        checkOutput({name, "/out"}, div_out, e.out);
        modelOut = e.out;
        if (e.lat == 33) begin
            cValid = 1'b1;
            cA     = e.a;
            cB     = e.b;
            cSgn   = e.sgn;
        end
        @(negedge clk);
        checkOutput({name, "/doneOnePulse"}, 32'(div_done), 32'd0);
        checkOutput({name, "/idleAfter"}, 32'(div_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{2'd0, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{2'd2, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{2'd3, 32'd100,        32'd7,          32'd2};
        vecs[3]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[4]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[5]  = '{2'd1, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC};
        vecs[6]  = '{2'd3, 32'hFFFF_FFF9,  32'd2,          32'd1};
        vecs[7]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[8]  = '{2'd3, 32'd5,          32'd0,          32'd5};
        vecs[9]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[10] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[11] = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[12] = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[13] = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[14] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[15] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[16] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[17] = '{2'd0, 32'd0,          32'd5,          32'd0};

        rst       = 1'b1;
        div_start = 1'b0;
        div_flush = 1'b0;
        div_op    = 2'd0;
        div_in1   = '0;
        div_in2   = '0;
        cValid    = 1'b0;
        cA        = '0;
        cB        = '0;
        cSgn      = 1'b0;
        modelOut  = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset/busy", 32'(div_busy), 32'd0);
        checkOutput("reset/done", 32'(div_done), 32'd0);
        checkOutput("reset/out", div_out, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle/busy", 32'(div_busy), 32'd0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            @(negedge clk);
            div_start = 1'b0;
            waitDone($sformatf("vec%0d", i), 0, 0, 0);
        end

        // Request pulsed mid-operation must be dropped, not queued.
        applyStimulus(2'd0, 32'd200, 32'd9, 32'd22);
        @(negedge clk);
        div_start = 1'b0;
        waitDone("ignoreStart", 5, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ignoreStart/noQueue%0d", k), 32'(div_busy), 32'd0);
        end

        applyStimulus(2'd0, 32'd1000, 32'd3, 32'd333);
        @(negedge clk);
        div_start = 1'b0;
        waitDone("flush", 0, 10, 0);
        applyStimulus(2'd0, 32'd1000, 32'd3, 32'd333);
        @(negedge clk);
        div_start = 1'b0;
        waitDone("afterFlush", 0, 0, 0);

        applyStimulus(2'd0, 32'd1000, 32'd7, 32'd142);
        @(negedge clk);
        div_start = 1'b0;
        waitDone("midReset", 0, 0, 20);
        applyStimulus(2'd1, 32'd100, 32'd7, 32'd14);
        @(negedge clk);
        div_start = 1'b0;
        waitDone("afterReset", 0, 0, 0);

        div_start = 1'b1;
        div_flush = 1'b1;
        div_op    = 2'd1;
        div_in1   = 32'd9;
        div_in2   = 32'd3;
        cValid    = 1'b0;
        @(negedge clk);
        div_start = 1'b0;
        div_flush = 1'b0;
        checkOutput("startFlushIdle/busy", 32'(div_busy), 32'd0);
        checkOutput("startFlushIdle/done", 32'(div_done), 32'd0);
        @(negedge clk);
        checkOutput("startFlushIdle/busyLater", 32'(div_busy), 32'd0);

        // Request held through the done cycle is taken one cycle after FIX.
        applyStimulus(2'd1, 32'd77, 32'd7, 32'd11);
        @(negedge clk);
        applyStimulus(2'd3, 32'd5, 32'd0, 32'd5);
        waitDone("holdA", 0, 0, 0);
        @(negedge clk);
        div_start = 1'b0;
        waitDone("holdB", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
